// File: rtl/router_pkg.sv
// Shared types, port map and header/route helpers for the mesh crossbar router.
package router_pkg;

    localparam int unsigned AXIS_DATA_WIDTH = 32;

    typedef struct packed {
        logic                       tvalid;
        logic [AXIS_DATA_WIDTH-1:0] tdata;
        logic                       tlast;
    } axis_mosi_t;

    typedef struct packed {
        logic tready;
    } axis_miso_t;

    // Mesh ports follow the local ports, so these are offsets from LOCAL_PORTS.
    localparam int unsigned PORT_NORTH = 0;
    localparam int unsigned PORT_EAST  = 1;
    localparam int unsigned PORT_SOUTH = 2;
    localparam int unsigned PORT_WEST  = 3;

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StDrop} in_state_e;

    function automatic int unsigned hdr_field(input logic [AXIS_DATA_WIDTH-1:0] data,
                                              input int unsigned lsb,
                                              input int unsigned width);
        logic [AXIS_DATA_WIDTH-1:0] mask;
        logic [AXIS_DATA_WIDTH-1:0] shifted;
        mask    = ~({AXIS_DATA_WIDTH{1'b1}} << width);
        shifted = (data >> lsb) & mask;
        return 32'(shifted);
    endfunction

    // XY routing: resolve the column first, then the row, then the local port.
    function automatic int unsigned route_compute(input int unsigned tx, input int unsigned ty,
                                                  input int unsigned tl, input int unsigned rx,
                                                  input int unsigned ry,
                                                  input int unsigned local_ports);
        if (tx > rx) return local_ports + PORT_EAST;
        if (tx < rx) return local_ports + PORT_WEST;
        if (ty > ry) return local_ports + PORT_SOUTH;
        if (ty < ry) return local_ports + PORT_NORTH;
        return tl;
    endfunction

endpackage

// File: rtl/router_out_arbiter.sv
// Locked round-robin arbiter for one router output; the grant is held until
// the packet's TLAST flit handshakes, then the pointer moves past the winner.
module router_out_arbiter #(
    parameter int unsigned N  = 6,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [N-1:0]  req_i,
    input  logic          release_i,
    output logic          locked_o,
    output logic [IW-1:0] gnt_o,
    output logic [N-1:0]  issue_o
);

    logic          locked_q, locked_d;
    logic [IW-1:0] gnt_q, gnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   cand;

    always_comb begin
        locked_d = locked_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        issue_o  = '0;
        found    = 1'b0;
        cand     = 0;
        if (locked_q) begin
            if (release_i) begin
                locked_d = 1'b0;
                ptr_d    = (gnt_q == IW'(N - 1)) ? '0 : gnt_q + 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = (32'(ptr_q) + k) % N;
                if (!found && req_i[IW'(cand)]) begin
                    found                = 1'b1;
                    locked_d             = 1'b1;
                    gnt_d                = IW'(cand);
                    issue_o[IW'(cand)]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            locked_q <= 1'b0;
            gnt_q    <= '0;
            ptr_q    <= '0;
        end else begin
            locked_q <= locked_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
        end
    end

    assign locked_o = locked_q;
    assign gnt_o    = gnt_q;

endmodule

// File: rtl/router_mesh_xbar.sv
// Mesh router node: per-input FIFO and route FSM, per-output locked round-robin
// arbiter, combinational crossbar from the granted FIFO head to each output.
module router_mesh_xbar
    import router_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned LOCAL_PORTS     = 2,
    parameter int unsigned BUFFER_LENGTH   = 16,
    parameter int unsigned MAX_ROUTERS_X   = 4,
    parameter int unsigned MAX_ROUTERS_Y   = 4,
    parameter int unsigned ROUTER_X        = 0,
    parameter int unsigned ROUTER_Y        = 0,
    localparam int unsigned CHANNEL_NUMBER = LOCAL_PORTS + 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  axis_mosi_t                in_mosi_i  [CHANNEL_NUMBER],
    output axis_miso_t                in_miso_o  [CHANNEL_NUMBER],
    output axis_mosi_t                out_mosi_o [CHANNEL_NUMBER],
    input  axis_miso_t                out_miso_i [CHANNEL_NUMBER],
    output logic [CHANNEL_NUMBER-1:0] drop_o
);

    localparam int unsigned X_W = (MAX_ROUTERS_X > 1) ? $clog2(MAX_ROUTERS_X) : 1;
    localparam int unsigned Y_W = (MAX_ROUTERS_Y > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
    localparam int unsigned L_W = (LOCAL_PORTS > 1) ? $clog2(LOCAL_PORTS) : 1;
    localparam int unsigned AW  = $clog2(BUFFER_LENGTH);
    localparam int unsigned PW  = $clog2(CHANNEL_NUMBER);

    logic                      empty     [CHANNEL_NUMBER];
    logic [DATA_WIDTH-1:0]     head_data [CHANNEL_NUMBER];
    logic                      head_last [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] req_by_in [CHANNEL_NUMBER];
    logic [CHANNEL_NUMBER-1:0] issue     [CHANNEL_NUMBER];
    logic                      out_valid [CHANNEL_NUMBER];
    logic                      out_hs    [CHANNEL_NUMBER];

    for (genvar i = 0; i < CHANNEL_NUMBER; i++) begin : g_in
        logic [AW:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
        logic [DATA_WIDTH:0]        mem_q [BUFFER_LENGTH];
        logic                       full, tready, push, pop, drop, granted, misaddr;
        logic [PW-1:0]              route_q, route_d, route_now;
        logic [CHANNEL_NUMBER-1:0]  req_vec;
        logic [AXIS_DATA_WIDTH-1:0] head_ext;
        int unsigned                tx, ty, tl;
        in_state_e                  state_q, state_d;

        assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        assign empty[i] = (wr_ptr_q == rd_ptr_q);
        assign tready   = rst_n_i && !full;
        assign push     = in_mosi_i[i].tvalid && tready;
        assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

        assign in_miso_o[i]                  = axis_miso_t'{tready: tready};
        assign {head_last[i], head_data[i]}  = mem_q[rd_ptr_q[AW-1:0]];
        assign head_ext  = AXIS_DATA_WIDTH'(head_data[i]);
        assign tx        = hdr_field(head_ext, 0, X_W);
        assign ty        = hdr_field(head_ext, X_W, Y_W);
        assign tl        = hdr_field(head_ext, X_W + Y_W, L_W);
        assign misaddr   = (tx >= MAX_ROUTERS_X) || (ty >= MAX_ROUTERS_Y) || (tl >= LOCAL_PORTS);
        assign route_now = PW'(route_compute(tx, ty, tl, ROUTER_X, ROUTER_Y, LOCAL_PORTS));
        assign req_by_in[i] = req_vec;
        assign drop_o[i]    = drop;

        always_comb begin
            granted = 1'b0;
            for (int o = 0; o < CHANNEL_NUMBER; o++) granted = granted | issue[o][i];
        end

        // Request straight from IDLE so a fresh header is granted the cycle after its write.
        always_comb begin
            req_vec = '0;
            if (state_q == StIdle && !empty[i] && !misaddr) req_vec[route_now] = 1'b1;
            else if (state_q == StReq)                       req_vec[route_q]   = 1'b1;
        end

        always_comb begin
            state_d = state_q;
            route_d = route_q;
            pop     = 1'b0;
            drop    = 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!empty[i]) begin
                        if (misaddr) begin
                            pop     = 1'b1;
                            drop    = 1'b1;
                            state_d = head_last[i] ? StIdle : StDrop;
                        end else begin
                            route_d = route_now;
                            state_d = granted ? StXfer : StReq;
                        end
                    end
                end
                StReq: if (granted) state_d = StXfer;
                StXfer: begin
                    if (out_hs[route_q]) begin
                        pop = 1'b1;
                        if (head_last[i]) state_d = StIdle;
                    end
                end
                StDrop: begin
                    if (!empty[i]) begin
                        pop = 1'b1;
                        if (head_last[i]) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                route_q  <= '0;
                state_q  <= StIdle;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                route_q  <= route_d;
                state_q  <= state_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_mosi_i[i].tlast, in_mosi_i[i].tdata[DATA_WIDTH-1:0]};
        end
    end

    for (genvar o = 0; o < CHANNEL_NUMBER; o++) begin : g_out
        logic                      locked;
        logic [PW-1:0]             gnt;
        logic [CHANNEL_NUMBER-1:0] req_col;

        always_comb begin
            req_col = '0;
            for (int i = 0; i < CHANNEL_NUMBER; i++) req_col[i] = req_by_in[i][o];
        end

        assign out_valid[o]  = locked && !empty[gnt];
        assign out_hs[o]     = out_valid[o] && out_miso_i[o].tready;
        assign out_mosi_o[o] = axis_mosi_t'{tvalid: out_valid[o],
                                            tdata:  AXIS_DATA_WIDTH'(head_data[gnt]),
                                            tlast:  head_last[gnt]};

        router_out_arbiter #(
            .N(CHANNEL_NUMBER)
        ) u_arb (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .req_i    (req_col),
            .release_i(out_hs[o] && head_last[gnt]),
            .locked_o (locked),
            .gnt_o    (gnt),
            .issue_o  (issue[o])
        );
    end

endmodule
